// File: rtl/fpu_sub_arbiter.sv
// Round-robin arbiter sharing one fixed-latency fp_subtract between two requesters.
// Define FPU_SUB_ARB_STATS_EN to add per-requester saturating completion counters.
module fpu_sub_arbiter #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_valid,
    input  logic [31:0] fpu_diff,
    input  logic        fpu_error,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_diff,
    output logic        rsp_error
`ifdef FPU_SUB_ARB_STATS_EN
    ,
    output logic [15:0] stat_ops0,
    output logic [15:0] stat_ops1
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q;
    logic        last_q;
    logic        id_q;
    logic [31:0] a_q, b_q;
    logic [31:0] diff_q;
    logic        err_q;
    logic        grant_id;
    logic        accept;

    // On a tie the requester not granted last wins; rst masks ready so outputs are 0 in reset.
    always_comb begin
        grant_id = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        accept   = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
    end

    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept & grant_id;
    assign fpu_valid  = (state_q == ISSUE);
    assign rsp_valid  = (state_q == RESP);
    assign fpu_a      = a_q;
    assign fpu_b      = b_q;
    assign rsp_id     = id_q;
    assign rsp_diff   = diff_q;
    assign rsp_error  = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == 8'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            diff_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q <= grant_id;
                a_q  <= grant_id ? req1_a : req0_a;
                b_q  <= grant_id ? req1_b : req0_b;
            end
            if (state_q == ISSUE) begin
                cnt_q <= 8'(LATENCY);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 8'd1;
            end
            // The subtractor result is valid in the last WAIT cycle only.
            if (state_q == WAIT && cnt_q == 8'd1) begin
                diff_q <= fpu_diff;
                err_q  <= fpu_error;
            end
            if (state_q == RESP) begin
                last_q <= id_q;
            end
        end
    end

`ifdef FPU_SUB_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops0 <= 16'd0;
            stat_ops1 <= 16'd0;
        end else if (state_q == RESP) begin
            if (!id_q && stat_ops0 != 16'hFFFF) stat_ops0 <= stat_ops0 + 16'd1;
            if (id_q && stat_ops1 != 16'hFFFF)  stat_ops1 <= stat_ops1 + 16'd1;
        end
    end
`endif

endmodule
